// File: rtl/dca_lpi_port_arbiter2.sv
// dca_lpi_port_arbiter2
// Shares one LPI request/response port between two DCA matrix LSUs in front
// of the XMI bridge. Bursts are granted round-robin and held until the last
// request beat. The source of each granted burst is queued in an in-order
// tracker so responses can be steered back without touching the burden field.
//
// Ports
//   clk, rstnn            clock, asynchronous active-high reset
//   clear                 synchronous soft reset (wins over every other event)
//   busy                  grant held or responses still owed
//   err_orphan            sticky: response seen with nothing outstanding
//   m0_*/m1_*             requester-side request (q) and response (y) channels
//   s_*                   shared XMI-side request (q) and response (y) channels
module dca_lpi_port_arbiter2 #(
    parameter int BW_QDATA    = 96,
    parameter int BW_YDATA    = 40,
    parameter int OUTSTANDING = 4
) (
    input  logic                clk,
    input  logic                rstnn,
    input  logic                clear,
    output logic                busy,
    output logic                err_orphan,
    input  logic                m0_qvalid,
    input  logic                m0_qlast,
    input  logic [BW_QDATA-1:0] m0_qdata,
    output logic                m0_qready,
    output logic                m0_yvalid,
    output logic                m0_ylast,
    output logic [BW_YDATA-1:0] m0_ydata,
    input  logic                m0_yready,
    input  logic                m1_qvalid,
    input  logic                m1_qlast,
    input  logic [BW_QDATA-1:0] m1_qdata,
    output logic                m1_qready,
    output logic                m1_yvalid,
    output logic                m1_ylast,
    output logic [BW_YDATA-1:0] m1_ydata,
    input  logic                m1_yready,
    output logic                s_qvalid,
    output logic                s_qlast,
    output logic [BW_QDATA-1:0] s_qdata,
    input  logic                s_qready,
    input  logic                s_yvalid,
    input  logic                s_ylast,
    input  logic [BW_YDATA-1:0] s_ydata,
    output logic                s_yready
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam logic [PW:0] PTR_ONE = 1;

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_rr_last;
    logic                   r_err_orphan;
    logic [OUTSTANDING-1:0] r_trk;          // one source bit per outstanding burst
    logic [PW:0]            r_wptr, r_rptr; // extra MSB separates full from empty

    logic w_empty, w_full, w_head;
    logic w_push, w_push_id, w_pop;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
    assign w_head  = r_trk[r_rptr[PW-1:0]];

    // Request side: arbitration in IDLE, pass-through while granted.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_id   = 1'b0;
        s_qvalid    = 1'b0;
        s_qlast     = 1'b0;
        s_qdata     = '0;
        m0_qready   = 1'b0;
        m1_qready   = 1'b0;
        case (r_state)
            IDLE: begin
                // Full is the registered flag: a pop this cycle does not free a slot yet.
                if (!w_full && (m0_qvalid || m1_qvalid)) begin
                    w_push      = 1'b1;
                    w_push_id   = (m0_qvalid && m1_qvalid) ? ~r_rr_last : m1_qvalid;
                    w_state_nxt = w_push_id ? GRANT1 : GRANT0;
                end
            end
            GRANT0: begin
                s_qvalid  = m0_qvalid;
                s_qlast   = m0_qlast;
                s_qdata   = m0_qdata;
                m0_qready = s_qready;
                if (m0_qvalid && s_qready && m0_qlast) w_state_nxt = IDLE;
            end
            GRANT1: begin
                s_qvalid  = m1_qvalid;
                s_qlast   = m1_qlast;
                s_qdata   = m1_qdata;
                m1_qready = s_qready;
                if (m1_qvalid && s_qready && m1_qlast) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Response side: steered by the tracker head, fully gated when empty.
    always_comb begin
        s_yready  = 1'b0;
        m0_yvalid = 1'b0;
        m0_ylast  = 1'b0;
        m0_ydata  = '0;
        m1_yvalid = 1'b0;
        m1_ylast  = 1'b0;
        m1_ydata  = '0;
        if (!w_empty) begin
            s_yready  = w_head ? m1_yready : m0_yready;
            m0_yvalid = s_yvalid & ~w_head;
            m0_ylast  = s_ylast  & ~w_head;
            m1_yvalid = s_yvalid &  w_head;
            m1_ylast  = s_ylast  &  w_head;
            m0_ydata  = s_ydata;
            m1_ydata  = s_ydata;
        end
    end

    assign w_pop      = !w_empty && s_yvalid && s_yready && s_ylast;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign err_orphan = r_err_orphan;

    always_ff @(posedge clk or posedge rstnn) begin
        if (rstnn) begin
            r_state      <= IDLE;
            r_rr_last    <= 1'b1;   // requester 0 wins the first tie
            r_err_orphan <= 1'b0;
            r_trk        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else if (clear) begin
            r_state      <= IDLE;
            r_rr_last    <= 1'b1;
            r_err_orphan <= 1'b0;
            r_trk        <= '0;
            r_wptr       <= '0;
            r_rptr       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_push) begin
                r_trk[r_wptr[PW-1:0]] <= w_push_id;
                r_wptr                <= r_wptr + PTR_ONE;
                r_rr_last             <= w_push_id;
            end
            if (w_pop) r_rptr <= r_rptr + PTR_ONE;
            if (w_empty && s_yvalid) r_err_orphan <= 1'b1;
        end
    end

endmodule

// File: doc/dca_lpi_port_arbiter2.md
# dca_lpi_port_arbiter2

Two-to-one arbiter that shares one LPI request/response port (slxq/slxy style) between two DCA matrix LSUs, for example a load LSU and a store LSU or two tensor LSUs, in front of the single XMI bridge.
- Requests are granted per burst, round-robin, and locked until the burst's last beat.
- Each granted burst's source is recorded in an in-order tracker FIFO, so responses can be routed back without modifying the burden field.
- The block sits between the LSU LPI ports and the XMI1P-side port.

## Interface
Parameters:
- BW_QDATA, 96, packed request payload width ({burden,write,len,size,burst,wstrb,wdata,addr}); passed through opaquely
- BW_YDATA, 40, packed response payload width ({burden,wreply,resp,rdata}); passed through opaquely
- OUTSTANDING, 4, tracker FIFO depth (power of two, ≥2); maximum granted bursts awaiting a response

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - clk, input, 1, clock
  - rstnn, input, 1, asynchronous reset, active-high (1 = reset)
- Control:
  - clear, input, 1, synchronous soft reset
  - busy, output, 1, grant active or tracker non-empty
  - err_orphan, output, 1, sticky: response arrived with tracker empty
- m0_qvalid/m0_qlast, input, 1 each, requester 0 request valid / last beat
- m0_qdata, input, BW_QDATA, requester 0 payload
- m0_qready, output, 1, requester 0 beat accepted
- m0_yvalid/m0_ylast, output, 1 each, response to requester 0
- m0_ydata, output, BW_YDATA, response payload
- m0_yready, input, 1, requester 0 accepts response
- m1_*, same seven ports for requester 1
- s_qvalid/s_qlast, output, 1 each, shared request
- s_qdata, output, BW_QDATA
- s_qready, input, 1
- s_yvalid/s_ylast, input, 1 each, shared response
- s_ydata, input, BW_YDATA
- s_yready, output, 1

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- IDLE:
  - If the tracker is not full and any mN_qvalid=1, select a requester. When both are requesting, take the one not indicated by rr_last; when one is requesting, take that one.
  - Next state GRANTN. Push N into the tracker. Set rr_last to N.
  - No beat is forwarded while in IDLE.
- GRANTN:
  - s_qvalid = mN_qvalid, s_qlast = mN_qlast, s_qdata = mN_qdata, mN_qready = s_qready. The other requester's qready is 0.
  - On the handshake of a beat with qlast=1, return to IDLE.
- Response routing uses the tracker head H, valid only when the tracker is non-empty:
  - mH_yvalid = s_yvalid, mH_ylast = s_ylast, s_yready = mH_yready.
  - Both requesters receive ydata = s_ydata.
  - On an s_y handshake with s_ylast=1, pop the tracker.
  - A write burst has a single response beat with ylast=1. A read burst has len+1 beats, with ylast on the final beat.
- With the tracker empty:
  - s_yready=0 and all m_yvalid=0.
  - If s_yvalid=1, set err_orphan=1. It stays set until clear or reset.
- Tracker: read/write pointers of log2(OUTSTANDING)+1 bits, wrapping modulo 2·OUTSTANDING.
  - full when the pointers differ only in the MSB; empty when they are equal.
  - A push and a pop in the same cycle leave the count unchanged.
- busy = (state≠IDLE) | ~empty.
- clear, and also reset:
  - state → IDLE, tracker emptied, rr_last → 1 (so requester 0 wins the first tie), err_orphan → 0.
  - clear takes priority over every event in that cycle. Bursts in flight are abandoned; the requesters must also be cleared.

## Timing
- Reset values: every output 0. mN_ydata and s_qdata are 0 only because they are gated by the zero grant/empty state. busy=0, err_orphan=0.
- Arbitration latency: 1 cycle. A qvalid seen in IDLE is forwarded from the next cycle.
- Minimum gap between bursts: 1 IDLE cycle after each last beat.
- Request and response paths are combinational pass-through, with no added latency once granted or tracked.
- Full-tracker boundary: a grant is blocked when the tracker is full at IDLE, even if a pop occurs in that same cycle. The grant proceeds on the following cycle.
- The response to a burst may be popped in the same cycle that a new burst is pushed.
- The requester keeps its qvalid/qdata stable until qready. The arbiter never drops a granted burst except on clear.

## Test plan
- Single write:
  - Stimulus: m0 sends 1 beat (qlast=1); s_qready=1; then the response s_yvalid=1, s_ylast=1.
  - Required: s_qvalid high exactly 1 cycle after m0_qvalid. m0_yvalid=1, m1_yvalid=0. busy falls the cycle after the pop.
- Round-robin fairness:
  - Stimulus: m0 and m1 continuously request 2-beat bursts.
  - Required: grants alternate 0,1,0,1 starting with 0. Each burst occupies 2 GRANT cycles plus 1 IDLE cycle.
- Tracker full:
  - Stimulus: OUTSTANDING=4, 5 bursts from m1, no responses.
  - Required: 4 bursts are forwarded and the 5th stays in IDLE. After one response ylast, the 5th is granted on the next-but-one cycle.
- In-order routing:
  - Stimulus: grants m0 (read, len=3) then m1 (write).
  - Required: 4 beats go to m0 with ylast on beat 4, then 1 beat to m1. yready backpressure from m0 stalls s_yready.
- Orphan response:
  - Stimulus: s_yvalid=1 with the tracker empty.
  - Required: s_yready=0, no m_yvalid, err_orphan=1 and it stays set. A clear pulse returns it to 0.
- Mid-burst reset and clear:
  - Stimulus: assert rstnn=1 during beat 2 of a 4-beat burst with 2 bursts outstanding.
  - Required: all outputs are 0 immediately (asynchronous) and busy=0. After release, the next grant goes to m0 on a tie.
  - Repeat with clear; the same result is required one clock later.
